// File: rtl/pg_switch_ctrl_pkg.sv
// Shared definitions for the NoC switch power-gating controller:
// state encodings and default timing parameters.
package pg_switch_ctrl_pkg;

  typedef enum logic [1:0] {
    PG_ON   = 2'd0,
    PG_ISO  = 2'd1,
    PG_OFF  = 2'd2,
    PG_WAKE = 2'd3
  } pg_state_e;

  localparam int DEF_IDLE_CYCLES = 16;
  localparam int DEF_WAKE_CYCLES = 4;

endpackage

// File: rtl/pg_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module pg_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         a_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (a_rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pg_switch_ctrl.sv
// Per-node power-gating controller for one NoC switch: gates after an idle
// period, isolates/holds off writers while unpowered, sequences wake-up.
module pg_switch_ctrl
  import pg_switch_ctrl_pkg::*;
#(
  parameter int PORTS_NUM   = 5,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int CNT_W       = 8,
  parameter int STAT_W      = 32
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic [PORTS_NUM-1:0] in_w,
  input  logic [PORTS_NUM-1:0] out_w,
  input  logic                 sw_busy,
  input  logic                 force_on,
  output logic                 sleep_o,
  output logic                 iso_o,
  output logic                 sw_rst_o,
  output logic [PORTS_NUM-1:0] in_r_mask,
  output logic [1:0]           state_o,
  output logic [STAT_W-1:0]    gated_cnt
);

  localparam bit             GATE_EN   = (IDLE_CYCLES != 0);
  localparam logic [CNT_W-1:0] IDLE_LAST = GATE_EN ? CNT_W'(IDLE_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  pg_state_e              r_state;
  pg_state_e              w_state_nxt;
  logic [CNT_W-1:0]       r_idle_cnt, w_idle_nxt;
  logic [CNT_W-1:0]       r_wake_cnt, w_wake_nxt;
  logic                   r_sleep, r_iso, r_sw_rst;
  logic [PORTS_NUM-1:0]   r_mask;
  logic                   w_activity, w_wake_req;

  assign w_activity = (|in_w) | (|out_w) | sw_busy | force_on;
  // Outputs of a gated switch are clamped, so only upstream writes can wake it.
  assign w_wake_req = (|in_w) | force_on;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    w_wake_nxt  = r_wake_cnt;
    case (r_state)
      PG_ON: begin
        if (w_activity || !GATE_EN) begin
          w_idle_nxt = '0;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_state_nxt = PG_ISO;
          w_idle_nxt  = '0;
        end else begin
          w_idle_nxt = r_idle_cnt + 1'b1;
        end
      end
      PG_ISO: begin
        w_idle_nxt  = '0;
        w_state_nxt = w_activity ? PG_ON : PG_OFF;
      end
      PG_OFF: begin
        if (w_wake_req) begin
          w_state_nxt = PG_WAKE;
          w_wake_nxt  = '0;
        end
      end
      PG_WAKE: begin
        if (r_wake_cnt == WAKE_LAST) begin
          w_state_nxt = PG_ON;
          w_idle_nxt  = '0;
        end else begin
          w_wake_nxt = r_wake_cnt + 1'b1;
        end
      end
      default: w_state_nxt = PG_ON;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (a_rst) begin
      r_state    <= PG_ON;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_sleep    <= 1'b0;
      r_iso      <= 1'b0;
      r_sw_rst   <= 1'b0;
      r_mask     <= '1;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_wake_cnt <= w_wake_nxt;
      // Outputs are decoded from the next state so they change with the state.
      r_sleep    <= (w_state_nxt == PG_OFF);
      r_iso      <= (w_state_nxt != PG_ON);
      r_sw_rst   <= (w_state_nxt == PG_OFF) || (w_state_nxt == PG_WAKE);
      r_mask     <= {PORTS_NUM{w_state_nxt == PG_ON}};
    end
  end

  pg_sat_counter #(.W(STAT_W)) u_gated_cnt (
    .clk   (clk),
    .a_rst (a_rst),
    .i_inc (r_state == PG_OFF),
    .o_cnt (gated_cnt)
  );

  assign sleep_o   = r_sleep;
  assign iso_o     = r_iso;
  assign sw_rst_o  = r_sw_rst;
  assign in_r_mask = r_mask;
  assign state_o   = r_state;

endmodule

// File: tb/tb_pg_switch_ctrl.sv
// Directed bench for pg_switch_ctrl: gating, wake-up, expiry races, reset,
// never-gate configuration and counter saturation.
module tb_pg_switch_ctrl;

  localparam int P = 5;

  logic         clk = 1'b0;
  logic         a_rst;
  logic [P-1:0] in_w, out_w;
  logic         sw_busy, force_on;
  logic         sleep_o, iso_o, sw_rst_o;
  logic [P-1:0] in_r_mask;
  logic [1:0]   state_o;
  logic [31:0]  gated_cnt;

  logic [P-1:0] z_w = '0;
  logic         z_b = 1'b0;
  logic         n_sleep, n_iso, n_rst;
  logic [P-1:0] n_mask;
  logic [1:0]   n_state;
  logic [31:0]  n_gated;
  logic         s_sleep, s_iso, s_rst;
  logic [P-1:0] s_mask;
  logic [1:0]   s_state;
  logic [3:0]   s_gated;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pg_switch_ctrl #(.PORTS_NUM(P), .IDLE_CYCLES(16), .WAKE_CYCLES(4), .CNT_W(8), .STAT_W(32)) dut (
    .clk(clk), .a_rst(a_rst), .in_w(in_w), .out_w(out_w), .sw_busy(sw_busy),
    .force_on(force_on), .sleep_o(sleep_o), .iso_o(iso_o), .sw_rst_o(sw_rst_o),
    .in_r_mask(in_r_mask), .state_o(state_o), .gated_cnt(gated_cnt)
  );

  pg_switch_ctrl #(.PORTS_NUM(P), .IDLE_CYCLES(0), .WAKE_CYCLES(4), .CNT_W(8), .STAT_W(32)) dut_noidle (
    .clk(clk), .a_rst(a_rst), .in_w(z_w), .out_w(z_w), .sw_busy(z_b),
    .force_on(z_b), .sleep_o(n_sleep), .iso_o(n_iso), .sw_rst_o(n_rst),
    .in_r_mask(n_mask), .state_o(n_state), .gated_cnt(n_gated)
  );

  pg_switch_ctrl #(.PORTS_NUM(P), .IDLE_CYCLES(16), .WAKE_CYCLES(4), .CNT_W(8), .STAT_W(4)) dut_sat (
    .clk(clk), .a_rst(a_rst), .in_w(z_w), .out_w(z_w), .sw_busy(z_b),
    .force_on(z_b), .sleep_o(s_sleep), .iso_o(s_iso), .sw_rst_o(s_rst),
    .in_r_mask(s_mask), .state_o(s_state), .gated_cnt(s_gated)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 ns after the edge, inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic seen;

  initial begin
    a_rst = 1'b1; in_w = '0; out_w = '0; sw_busy = 1'b0; force_on = 1'b0;
    tick_n(2);
    check("rst_state", state_o, 0);
    check("rst_sleep", sleep_o, 0);
    check("rst_iso",   iso_o, 0);
    check("rst_swrst", sw_rst_o, 0);
    check("rst_mask",  in_r_mask, 5'h1f);
    check("rst_gated", gated_cnt, 0);
    a_rst = 1'b0;

    // Idle from reset: ISO at edge 16, OFF at edge 17, counting from edge 18
    tick_n(15);
    check("t1_iso_e15", iso_o, 0);
    check("t1_state_e15", state_o, 0);
    tick();
    check("t1_iso_e16", iso_o, 1);
    check("t1_state_e16", state_o, 1);
    check("t1_sleep_e16", sleep_o, 0);
    check("t1_mask_e16", in_r_mask, 0);
    tick();
    check("t1_sleep_e17", sleep_o, 1);
    check("t1_state_e17", state_o, 2);
    check("t1_swrst_e17", sw_rst_o, 1);
    check("t1_gated_e17", gated_cnt, 0);
    tick();
    check("t1_gated_e18", gated_cnt, 1);
    tick_n(2);
    check("t1_gated_e20", gated_cnt, 3);

    // Wake on in_w[2]: sleep drops at the first edge, mask opens at the fifth
    in_w = 5'b00100;
    out_w = 5'b11111;
    tick();
    check("t2_sleep_e1", sleep_o, 0);
    check("t2_state_e1", state_o, 3);
    check("t2_iso_e1",   iso_o, 1);
    check("t2_swrst_e1", sw_rst_o, 1);
    tick_n(3);
    check("t2_mask_e4",  in_r_mask, 0);
    check("t2_state_e4", state_o, 3);
    tick();
    check("t2_mask_e5",  in_r_mask, 5'h1f);
    check("t2_iso_e5",   iso_o, 0);
    check("t2_swrst_e5", sw_rst_o, 0);
    check("t2_state_e5", state_o, 0);
    check("t2_gated",    gated_cnt, 4);
    in_w = '0; out_w = '0;

    // Activity exactly at expiry keeps the switch on and restarts the count
    tick_n(15);
    in_w = 5'b00001;
    tick();
    check("t3_state", state_o, 0);
    check("t3_iso", iso_o, 0);
    in_w = '0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (iso_o) seen = 1'b1;
    end
    check("t3_iso_never", seen, 0);
    tick();
    check("t3_iso_after16", iso_o, 1);

    // force_on during ISO returns to ON without ever sleeping
    force_on = 1'b1;
    tick();
    check("t4_state", state_o, 0);
    check("t4_iso", iso_o, 0);
    check("t4_sleep", sleep_o, 0);
    force_on = 1'b0;

    // Buffered flits block gating indefinitely
    sw_busy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (state_o != 2'd0) seen = 1'b1;
    end
    check("t4_busy_on", seen, 0);
    sw_busy = 1'b0;
    tick_n(16);
    check("t4_iso_post_busy", state_o, 1);

    // Reset during WAKE (wake_cnt=2) wins over a held force_on
    tick();
    check("t5_off", state_o, 2);
    force_on = 1'b1;
    tick_n(3);
    check("t5_wake", state_o, 3);
    a_rst = 1'b1;
    tick();
    check("t5_rst_state", state_o, 0);
    check("t5_rst_sleep", sleep_o, 0);
    check("t5_rst_iso",   iso_o, 0);
    check("t5_rst_swrst", sw_rst_o, 0);
    check("t5_rst_mask",  in_r_mask, 5'h1f);
    check("t5_rst_gated", gated_cnt, 0);
    a_rst = 1'b0;
    force_on = 1'b0;

    // IDLE_CYCLES=0 never gates; STAT_W=4 counter saturates at 15
    seen = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (n_state != 2'd0 || n_iso || n_sleep) seen = 1'b1;
      if (k == 31)   check("t6_sat_e31", s_gated, 14);
      if (k == 32)   check("t6_sat_e32", s_gated, 15);
      if (k == 1000) check("t6_sat_e1000", s_gated, 15);
    end
    check("t5_noidle_on", seen, 0);
    check("t6_sat_sleep", s_sleep, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
